// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for a 5-stage in-order pipeline. It decides,
// every cycle, which pipeline buffers load, which load a bubble, and whether
// the PC advances. It also tracks long data-memory waits and traps into an
// error state if a wait lasts too long.
//
// Event priority, highest first:
//   error trap > data-memory wait > taken branch > load-use > fetch stall
//
// Parameters
//   TIMEOUT          max consecutive MEM_WAIT cycles before the error trap (>= 1)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_uses_rs1/rs2  the ID instruction really reads that source
//   ex_rd            destination register of the instruction in EX
//   ex_MemRead       EX instruction is a load
//   ex_branch_taken  branch/jump resolved taken in EX this cycle
//   i_mem_ready      instruction fetch data valid this cycle
//   m_mem_req        MEM-stage data access pending
//   m_mem_ready      MEM-stage data access completes this cycle
//   stall_cnt_clr    synchronous clear of stall_count (wins over increment)
//   pc_en            PC update enable
//   *_en             pipeline buffer load enables (0 = hold)
//   *_flush          load a bubble into that buffer (always paired with en=1)
//   state            RUN=0, MEM_WAIT=1, ERR=2
//   mem_timeout      sticky error flag, cleared only by reset
//   stall_count      saturating count of cycles with pc_en=0 outside ERR
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MemRead,
  input  logic        ex_branch_taken,
  input  logic        i_mem_ready,
  input  logic        m_mem_req,
  input  logic        m_mem_ready,
  input  logic        stall_cnt_clr,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  // The wait counter holds 0..TIMEOUT-1: it is the number of MEM_WAIT cycles
  // already spent before the current one.
  localparam int             WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]        state_q,       state_d;
  logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic mem_wait;
  logic load_use;

  // A data access that has not completed freezes everything up to MEM. In RUN
  // it only matters when a request is actually pending.
  assign mem_wait = ((state_q == ST_RUN) && m_mem_req && !m_mem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !m_mem_ready);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Enable/flush decode and next-state logic.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_count_d = stall_count_q;

    if (state_q == ST_ERR) begin
      // Freeze the whole machine; nothing moves until reset.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_wait) begin
      // Upstream holds; WB receives bubbles while the access is outstanding.
      // A taken branch in EX is simply held with EX and acted on later.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions; a pending load-use or fetch
      // stall belongs to the squashed path and is ignored.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!i_mem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (m_mem_req && !m_mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (m_mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          // This is the TIMEOUT-th consecutive wait cycle.
          state_d       = ST_ERR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_ERR: state_d = ST_ERR;
      // An unencoded state means corrupted control; trap rather than resume.
      default: begin
        state_d       = ST_ERR;
        mem_timeout_d = 1'b1;
      end
    endcase

    // Clear wins over a same-cycle increment; the count saturates at all-ones.
    if (stall_cnt_clr) begin
      stall_count_d = '0;
    end else if ((state_q != ST_ERR) && !pc_en && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4). Each stimulus step
// pushes its hand-derived expected outputs onto a scoreboard queue; a monitor
// pops and compares them on the falling edge, mid-cycle, while the inputs of
// that step are applied. Registered outputs are expected at their pre-edge
// value for that cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}
  localparam logic [8:0] NORM = 9'b1_1111_0000;
  localparam logic [8:0] LU   = 9'b0_0111_0100;
  localparam logic [8:0] BR   = 9'b1_1111_1100;
  localparam logic [8:0] FS   = 9'b0_1111_1000;
  localparam logic [8:0] MW   = 9'b0_0001_0001;
  localparam logic [8:0] ER   = 9'b0_0000_0000;

  typedef struct packed {
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       irdy;
    logic       req;
    logic       mrdy;
    logic       clr;
  } stim_t;

  typedef struct {
    string       tag;
    logic [8:0]  ctl;
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc;
  } exp_t;

  logic        clk, rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken;
  logic        i_mem_ready, m_mem_req, m_mem_ready, stall_cnt_clr;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_MemRead     (ex_MemRead),
    .ex_branch_taken(ex_branch_taken),
    .i_mem_ready    (i_mem_ready),
    .m_mem_req      (m_mem_req),
    .m_mem_ready    (m_mem_ready),
    .stall_cnt_clr  (stall_cnt_clr),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_flush   (mem_wb_flush),
    .state          (state),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [8:0] ctl_now();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  function automatic stim_t mk(input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd,  input logic mr,
                               input logic br, input logic irdy, input logic req,
                               input logic mrdy, input logic clr);
    stim_t s;
    s = '{rs1:rs1, u1:u1, rs2:rs2, u2:u2, rd:rd, mr:mr,
          br:br, irdy:irdy, req:req, mrdy:mrdy, clr:clr};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_rs1 = s.rs1;  id_uses_rs1 = s.u1;
    id_rs2 = s.rs2;  id_uses_rs2 = s.u2;
    ex_rd  = s.rd;   ex_MemRead  = s.mr;
    ex_branch_taken = s.br;
    i_mem_ready     = s.irdy;
    m_mem_req       = s.req;
    m_mem_ready     = s.mrdy;
    stall_cnt_clr   = s.clr;
  endtask

  // One clock cycle: apply inputs, queue the expectation, advance past the edge.
  task automatic step(input string tag, input stim_t s, input logic [8:0] ctl,
                      input logic [1:0] st, input logic to, input logic [15:0] sc);
    exp_t e;
    e = '{tag:tag, ctl:ctl, st:st, to:to, sc:sc};
    drive(s);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "/ctl"},   32'(ctl_now()),   32'(e.ctl));
      check({e.tag, "/state"}, 32'(state),       32'(e.st));
      check({e.tag, "/to"},    32'(mem_timeout), 32'(e.to));
      check({e.tag, "/cnt"},   32'(stall_count), 32'(e.sc));
    end
  end

  initial begin
    stim_t q, mwr, fs;
    q   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    mwr = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    fs  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    drive(q);
    rst_n = 1'b0;
    #12;
    check("rst/state", 32'(state), 32'(RUN));
    check("rst/to",    32'(mem_timeout), 32'd0);
    check("rst/cnt",   32'(stall_count), 32'd0);
    check("rst/ctl",   32'(ctl_now()), 32'(NORM));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use detection and its one-cycle bubble.
    step("idle",      q,                                       NORM, RUN, 0, 0);
    step("lu_rs2",    mk(3, 1, 5, 1, 5, 1, 0, 1, 0, 1, 0),     LU,   RUN, 0, 0);
    step("lu_after",  q,                                       NORM, RUN, 0, 1);
    step("lu_x0",     mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0),     NORM, RUN, 0, 1);
    step("lu_unused", mk(7, 0, 2, 1, 7, 1, 0, 1, 0, 1, 0),     NORM, RUN, 0, 1);
    step("lu_rs1",    mk(9, 1, 2, 1, 9, 1, 0, 1, 0, 1, 0),     LU,   RUN, 0, 1);
    step("no_load",   mk(9, 1, 0, 0, 9, 0, 0, 1, 0, 1, 0),     NORM, RUN, 0, 2);

    // Branch priority over load-use and fetch stall.
    step("br_lu",     mk(4, 1, 0, 0, 4, 1, 1, 1, 0, 1, 0),     BR,   RUN, 0, 2);
    step("idle2",     q,                                       NORM, RUN, 0, 2);
    step("fetch",     fs,                                      FS,   RUN, 0, 2);
    step("br_fetch",  mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),     BR,   RUN, 0, 3);

    // Data-memory wait: 3 low-ready cycles with a branch held in EX.
    step("mw_enter",  mwr,                                     MW,   RUN,  0, 3);
    step("mw_br1",    mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0),     MW,   WAIT, 0, 4);
    step("mw_br2",    mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0),     MW,   WAIT, 0, 5);
    step("mw_end_br", mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0),     BR,   WAIT, 0, 6);
    step("mw_run",    q,                                       NORM, RUN,  0, 6);
    step("req_hit",   mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0),     NORM, RUN,  0, 6);
    step("mw_lu",     mk(5, 1, 0, 0, 5, 1, 0, 1, 1, 0, 0),     MW,   RUN,  0, 6);
    step("mw_end_lu", mk(5, 1, 0, 0, 5, 1, 0, 1, 1, 1, 0),     LU,   WAIT, 0, 7);

    // Counter clear, including clear against a concurrent stall.
    step("clr",       mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1),     NORM, RUN, 0, 8);
    step("clr_done",  q,                                       NORM, RUN, 0, 0);
    step("clr_fs",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),     FS,   RUN, 0, 0);
    step("clr_fs2",   q,                                       NORM, RUN, 0, 0);

    // Timeout: entry cycle plus 4 MEM_WAIT cycles, then ERR.
    step("to_enter",  mwr, MW, RUN, 0, 0);
    for (int k = 1; k <= 4; k++) step($sformatf("to_wait%0d", k), mwr, MW, WAIT, 0, 16'(k));
    step("err",       mwr,                                     ER,   ERR, 1, 5);
    step("err_hold",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0),     ER,   ERR, 1, 5);

    drive(q);
    rst_n = 1'b0;
    #1;
    check("err_rst/state", 32'(state), 32'(RUN));
    check("err_rst/to",    32'(mem_timeout), 32'd0);
    check("err_rst/cnt",   32'(stall_count), 32'd0);
    check("err_rst/ctl",   32'(ctl_now()), 32'(NORM));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_err", q, NORM, RUN, 0, 0);

    // Reset in the middle of a wait.
    step("w_enter", mwr, MW, RUN,  0, 0);
    step("w_wait",  mwr, MW, WAIT, 0, 1);
    drive(q);
    rst_n = 1'b0;
    #1;
    check("wait_rst/state", 32'(state), 32'(RUN));
    check("wait_rst/ctl",   32'(ctl_now()), 32'(NORM));
    check("wait_rst/cnt",   32'(stall_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_wait", q, NORM, RUN, 0, 0);

    // Saturation: more than 65535 fetch stalls.
    drive(fs);
    repeat (65540) @(posedge clk);
    #1;
    step("sat_hold",    fs,                                    FS,   RUN, 0, 16'hFFFF);
    step("sat_clr",     mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),   FS,   RUN, 0, 16'hFFFF);
    step("sat_cleared", q,                                     NORM, RUN, 0, 0);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, max consecutive MEM_WAIT cycles before the error trap.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-006 ex_rd  input  5  destination register of the instruction in EX.
REQ-007 ex_MemRead  input  1  EX instruction is a load.
REQ-008 ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 i_mem_ready  input  1  instruction fetch data valid this cycle.
REQ-010 m_mem_req, m_mem_ready  input  1 each  MEM-stage data access pending / completed.
REQ-011 stall_cnt_clr  input  1  synchronous clear of stall_count.
REQ-012 pc_en  output  1  PC update enable.
REQ-013 if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline buffer load enables (0 = hold).
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load bubble (all control bits 0) into that buffer.
REQ-015 state  output  2  RUN=0, MEM_WAIT=1, ERR=2.
REQ-016 mem_timeout  output  1  sticky error flag.
REQ-017 stall_count  output  16  saturating count of cycles with pc_en=0.

Function
REQ-018 Enable/flush outputs are combinational from state and inputs; stall_count, mem_timeout, state and the wait counter are registered.
REQ-019 Every asserted flush is accompanied by its enable = 1; a buffer never sees flush=1 with en=0.
REQ-020 RUN, no hazard: all enables 1, all flushes 0.
REQ-021 Priority, highest first: ERR, MEM wait, branch taken, load-use, fetch stall.
REQ-022 MEM wait (RUN with m_mem_req=1, m_mem_ready=0, or in MEM_WAIT with m_mem_ready=0): pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_flush=1.
REQ-023 RUN -> MEM_WAIT when m_mem_req=1 and m_mem_ready=0; MEM_WAIT -> RUN in the cycle m_mem_ready=1; in that cycle lower-priority rules apply normally.
REQ-024 Wait counter: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle; when it reaches TIMEOUT with m_mem_ready still 0, next state ERR and mem_timeout set.
REQ-025 ERR: all enables 0, all flushes 0; leaves only via reset.
REQ-026 Branch taken: pc_en=1, if_id_flush=1, id_ex_flush=1, others normal; overrides load-use and fetch stall.
REQ-027 Branch taken during a MEM wait: no flush; acted on in the cycle the wait ends, since EX is frozen and ex_branch_taken stays asserted.
REQ-028 Load-use: ex_MemRead=1, ex_rd!=0, and (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd); then pc_en=0, if_id_en=0, id_ex_flush=1. Bubble lasts exactly one cycle.
REQ-029 Fetch stall (i_mem_ready=0, no higher-priority event): pc_en=0, if_id_flush=1, later stages run.
REQ-030 stall_count increments when pc_en=0 in RUN or MEM_WAIT; saturates at 0xFFFF; does not count in ERR.
REQ-031 stall_cnt_clr=1 clears stall_count to 0 and overrides a same-cycle increment.

Reset
REQ-032 Reset: state=RUN, wait counter=0, mem_timeout=0, stall_count=0.
REQ-033 Reset asserted mid-MEM_WAIT or in ERR: returns to RUN immediately; enables follow REQ-020 while inputs are quiet.

Verification
REQ-034 Load x5 in EX with ID reading rs2=x5 -> one cycle: pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_count=1.
REQ-035 Same as REQ-034 but ex_rd=0 -> no stall.
REQ-036 m_mem_req=1, ready low 3 cycles then high -> state MEM_WAIT for 3 cycles, mem_wb_flush=1, upstream frozen; RUN on ready; stall_count=3.
REQ-037 ex_branch_taken plus load-use hazard together -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall count.
REQ-038 TIMEOUT=4, ready held low -> ERR after 4 wait cycles, mem_timeout=1, all enables 0; rst_n pulse -> RUN, flags 0.
REQ-039 stall_count preloaded to 0xFFFF by 65535+ fetch stalls -> holds at 0xFFFF; stall_cnt_clr with concurrent stall -> 0.
